rv_instr_decode: RTL and testbench

Registered RV32I instruction decoder that feeds the execute ALU. Accepts a fetched 32-bit instruction and its PC over a valid/ready handshake. Produces the 11-bit ALU operation code {funct7[5], funct3, opcode}, register indices, the sign-extended immediate and control flags. The decoded bundle is held in an output register with its own valid/ready handshake, and a pipeline flush input discards it.

---
 rtl/rv_instr_decode_pkg.sv | 45 ++++
 rtl/rv_instr_decode_if.sv | 32 +++
 rtl/rv_instr_decode_imm_gen.sv | 25 ++
 rtl/rv_instr_decode.sv | 192 +++++++++++++++++++
 tb/tb_rv_instr_decode.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_instr_decode_pkg.sv
// Shared RV32I decode constants, immediate-format enum and the decoded bundle type.
package rv_decode_pkg;

    localparam int OP_W = 11;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_SLL   = 3'b001;
    localparam logic [2:0] F3_SR    = 3'b101;
    localparam logic [2:0] F3_JALR  = 3'b000;
    localparam logic [2:0] F3_LD_X3 = 3'b011;
    localparam logic [2:0] F3_LD_X6 = 3'b110;
    localparam logic [2:0] F3_LD_X7 = 3'b111;
    localparam logic [2:0] F3_ST_MAX = 3'b010;
    localparam logic [2:0] F3_BR_X2 = 3'b010;
    localparam logic [2:0] F3_BR_X3 = 3'b011;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    typedef struct packed {
        logic [OP_W-1:0] operation;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [31:0]     imm;
        logic [31:0]     pc;
        logic            writes_rd;
        logic            illegal;
    } dec_bundle_t;

endpackage

// File: rtl/rv_instr_decode_if.sv
// Fetch-side and execute-side handshake bundle of the RV32I decoder.
interface rv_instr_decode_if;
    import rv_decode_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [31:0]     in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [OP_W-1:0] out_operation;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic [31:0]     out_imm;
    logic [31:0]     out_pc;
    logic            out_writes_rd;
    logic            out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_operation, out_rs1, out_rs2, out_rd,
               out_imm, out_pc, out_writes_rd, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_operation, out_rs1, out_rs2, out_rd,
               out_imm, out_pc, out_writes_rd, out_illegal
    );

endinterface

// File: rtl/rv_instr_decode_imm_gen.sv
// Combinational RV32I immediate generator: selects and sign-extends by format.
module rv_imm_gen
    import rv_decode_pkg::*;
(
    input  logic [31:7] instr_i,
    input  imm_fmt_e    fmt_i,
    output logic [31:0] imm_o
);

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        imm_o = '0;
        case (fmt_i)
            IMM_I: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_S: imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B: imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                            instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_U: imm_o = {instr_i[31:12], 12'b0};
            IMM_J: imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                            instr_i[20], instr_i[30:21], 1'b0};
            default: imm_o = '0;
        endcase
    end

endmodule

// File: rtl/rv_instr_decode.sv
// Registered RV32I decoder with valid/ready on both sides and a flush input.
// Define DECODE_SKID_EN to add a one-entry skid buffer and a registered in_ready.
module rv_instr_decode
    import rv_decode_pkg::*;
#(
    parameter int COUNT_W = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    rv_instr_decode_if.slave   bus,
    output logic [COUNT_W-1:0] instr_count
);

    logic [31:0]  dec_instr;
    logic [31:0]  dec_pc;
    dec_bundle_t  dec_d;
    dec_bundle_t  out_q;
    logic         out_valid_q;
    logic         out_valid_d;
    logic         out_free;
    logic         accept;
    logic         load_out;
    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_d;

    logic [6:0]   opcode;
    logic [2:0]   funct3;
    logic         legal;
    logic         has_rs1;
    logic         has_rs2;
    logic         has_rd;
    logic         alt_bit;
    imm_fmt_e     fmt;
    logic [31:0]  imm_w;

    assign out_free = !out_valid_q || bus.out_ready;

`ifdef DECODE_SKID_EN
    logic        skid_valid_q;
    logic        skid_valid_d;
    logic [31:0] skid_instr_q;
    logic [31:0] skid_pc_q;
    logic        skid_load;

    // in_ready depends only on the skid flop and flush, never on out_ready.
    assign bus.in_ready = !flush && !skid_valid_q;
    assign accept       = bus.in_valid && bus.in_ready;
    assign dec_instr    = skid_valid_q ? skid_instr_q : bus.in_instr;
    assign dec_pc       = skid_valid_q ? skid_pc_q    : bus.in_pc;
    assign load_out     = !flush && out_free && (skid_valid_q || accept);
    assign skid_load    = accept && !out_free;

    always_comb begin
        skid_valid_d = skid_valid_q;
        if (flush)
            skid_valid_d = 1'b0;
        else if (skid_valid_q)
            skid_valid_d = !out_free;
        else
            skid_valid_d = skid_load;
    end

    always_ff @(posedge clock) begin
        if (reset)
            skid_valid_q <= 1'b0;
        else
            skid_valid_q <= skid_valid_d;
    end

    // NOTE: the skid payload is not reset; skid_valid_q alone qualifies it.
    always_ff @(posedge clock) begin
        if (skid_load) begin
            skid_instr_q <= bus.in_instr;
            skid_pc_q    <= bus.in_pc;
        end
    end
`else
    assign bus.in_ready = !flush && out_free;
    assign accept       = bus.in_valid && bus.in_ready;
    assign dec_instr    = bus.in_instr;
    assign dec_pc       = bus.in_pc;
    assign load_out     = accept;
`endif

    rv_imm_gen u_imm_gen (
        .instr_i (dec_instr[31:7]),
        .fmt_i   (fmt),
        .imm_o   (imm_w)
    );

    always_comb begin
        opcode  = dec_instr[6:0];
        funct3  = dec_instr[14:12];
        fmt     = IMM_NONE;
        legal   = 1'b1;
        has_rs1 = 1'b1;
        has_rs2 = 1'b0;
        has_rd  = 1'b1;
        case (opcode)
            OPC_OP: has_rs2 = 1'b1;
            OPC_OP_IMM: fmt = IMM_I;
            OPC_LOAD: begin
                fmt   = IMM_I;
                legal = !(funct3 == F3_LD_X3 || funct3 == F3_LD_X6 || funct3 == F3_LD_X7);
            end
            OPC_JALR: begin
                fmt   = IMM_I;
                legal = (funct3 == F3_JALR);
            end
            OPC_STORE: begin
                fmt     = IMM_S;
                has_rs2 = 1'b1;
                has_rd  = 1'b0;
                legal   = (funct3 <= F3_ST_MAX);
            end
            OPC_BRANCH: begin
                fmt     = IMM_B;
                has_rs2 = 1'b1;
                has_rd  = 1'b0;
                legal   = !(funct3 == F3_BR_X2 || funct3 == F3_BR_X3);
            end
            OPC_LUI: begin
                fmt     = IMM_U;
                has_rs1 = 1'b0;
            end
            OPC_JAL: begin
                fmt     = IMM_J;
                has_rs1 = 1'b0;
            end
            default: begin
                legal   = 1'b0;
                has_rs1 = 1'b0;
                has_rd  = 1'b0;
            end
        endcase

        // Only shifts and R-type use instr[30] to select the ALU variant.
        alt_bit = (opcode == OPC_OP) ||
                  (opcode == OPC_OP_IMM && (funct3 == F3_SLL || funct3 == F3_SR));

        dec_d         = '0;
        dec_d.pc      = dec_pc;
        dec_d.illegal = !legal;
        if (legal) begin
            dec_d.operation = {alt_bit & dec_instr[30], funct3, opcode};
            dec_d.rs1       = has_rs1 ? dec_instr[19:15] : 5'd0;
            dec_d.rs2       = has_rs2 ? dec_instr[24:20] : 5'd0;
            dec_d.rd        = has_rd  ? dec_instr[11:7]  : 5'd0;
            dec_d.writes_rd = has_rd && (dec_instr[11:7] != 5'd0);
            dec_d.imm       = imm_w;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        if (flush)
            out_valid_d = 1'b0;
        else if (load_out)
            out_valid_d = 1'b1;
        else if (bus.out_ready)
            out_valid_d = 1'b0;
    end

    assign count_d = (out_valid_q && bus.out_ready && !flush) ? count_q + COUNT_W'(1) : count_q;

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            count_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            count_q     <= count_d;
            if (load_out)
                out_q <= dec_d;
        end
    end

    assign bus.out_valid     = out_valid_q;
    assign bus.out_operation = out_q.operation;
    assign bus.out_rs1       = out_q.rs1;
    assign bus.out_rs2       = out_q.rs2;
    assign bus.out_rd        = out_q.rd;
    assign bus.out_imm       = out_q.imm;
    assign bus.out_pc        = out_q.pc;
    assign bus.out_writes_rd = out_q.writes_rd;
    assign bus.out_illegal   = out_q.illegal;
    assign instr_count       = count_q;

endmodule

// File: tb/tb_rv_instr_decode.sv
// Directed plus randomized bench for rv_instr_decode against a queue-based reference model.
module tb_rv_instr_decode;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] instr_count;

    rv_instr_decode_if dif ();

    rv_instr_decode #(.COUNT_W(32)) dut (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .bus         (dif),
        .instr_count (instr_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [10:0] op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        wr;
        logic        ill;
    } exp_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] q_instr[$];
    logic [31:0] q_pc[$];
    logic [31:0] m_count = '0;
    bit          m_zero  = 1'b1;
    bit          acc;
    int          idx;
    logic [31:0] base;
    logic [31:0] cur;
    bit          have;
    logic [31:0] t4_ins[3];

    localparam logic [31:0] I_ADDI = 32'hFFF08293;
    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_BEQ  = 32'hFE000CE3;
    localparam logic [31:0] I_AUI  = 32'h00000017;
    localparam logic [31:0] I_LW3  = 32'h00003083;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t ref_decode(input logic [31:0] ins);
        exp_t              e;
        logic [6:0]        opc;
        logic [2:0]        f3;
        string             cls;
        logic signed [11:0] i12;
        logic signed [11:0] s12;
        logic signed [12:0] b13;
        logic signed [20:0] j21;
        opc = ins[6:0];
        f3  = ins[14:12];
        i12 = ins[31:20];
        s12 = {ins[31:25], ins[11:7]};
        b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        j21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        e = '{op: '0, rs1: '0, rs2: '0, rd: '0, imm: '0, wr: 1'b0, ill: 1'b0};
        case (opc)
            7'b0110011:                         cls = "R";
            7'b0010011, 7'b0000011, 7'b1100111: cls = "I";
            7'b0100011:                         cls = "S";
            7'b1100011:                         cls = "B";
            7'b0110111:                         cls = "U";
            7'b1101111:                         cls = "J";
            default:                            cls = "X";
        endcase
        e.ill = (cls == "X") ||
                (opc == 7'b0000011 && f3 inside {3'd3, 3'd6, 3'd7}) ||
                (opc == 7'b0100011 && f3 > 3'd2) ||
                (opc == 7'b1100011 && f3 inside {3'd2, 3'd3}) ||
                (opc == 7'b1100111 && f3 != 3'd0);
        if (e.ill) return e;
        e.op = {1'b0, f3, opc};
        if (opc == 7'b0110011 || (opc == 7'b0010011 && (f3 == 3'd1 || f3 == 3'd5)))
            e.op[10] = ins[30];
        e.rs1 = (cls == "U" || cls == "J") ? 5'd0 : ins[19:15];
        e.rs2 = (cls == "R" || cls == "S" || cls == "B") ? ins[24:20] : 5'd0;
        e.rd  = (cls == "S" || cls == "B") ? 5'd0 : ins[11:7];
        e.wr  = (e.rd != 5'd0);
        case (cls)
            "I": e.imm = 32'(i12);
            "S": e.imm = 32'(s12);
            "B": e.imm = 32'(b13);
            "U": e.imm = {ins[31:12], 12'b0};
            "J": e.imm = 32'(j21);
            default: e.imm = '0;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  legal_ops[8];
        logic [31:0] r;
        int          sel;
        legal_ops = '{7'b0010011, 7'b0110011, 7'b0000011, 7'b0100011,
                      7'b1100011, 7'b0110111, 7'b1101111, 7'b1100111};
        r   = $urandom;
        sel = $urandom_range(0, 9);
        if (sel < 8) r[6:0] = legal_ops[sel];
        return r;
    endfunction

    task automatic compare_outputs();
        exp_t e;
        check("out_valid", 32'(dif.out_valid), 32'(q_instr.size() > 0));
        check("instr_count", instr_count, m_count);
        if (q_instr.size() > 0) begin
            e = ref_decode(q_instr[0]);
            check("operation", 32'(dif.out_operation), 32'(e.op));
            check("imm", dif.out_imm, e.imm);
            check("writes_rd", 32'(dif.out_writes_rd), 32'(e.wr));
            check("illegal", 32'(dif.out_illegal), 32'(e.ill));
            check("pc", dif.out_pc, q_pc[0]);
            if (!e.ill) begin
                check("rs1", 32'(dif.out_rs1), 32'(e.rs1));
                check("rs2", 32'(dif.out_rs2), 32'(e.rs2));
                check("rd", 32'(dif.out_rd), 32'(e.rd));
            end
        end else if (m_zero) begin
            check("zero_operation", 32'(dif.out_operation), 32'd0);
            check("zero_fields", {dif.out_rs1, dif.out_rs2, dif.out_rd,
                                  dif.out_writes_rd, dif.out_illegal}, 32'd0);
            check("zero_imm", dif.out_imm, 32'd0);
            check("zero_pc", dif.out_pc, 32'd0);
        end
    endtask

    // Called just after a falling edge; applies inputs for one rising edge.
    task automatic run_cycle(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                             input bit ordy, input bit fl, input bit rst, output bit accepted);
        bit rdy;
        dif.in_valid  = v;
        dif.in_instr  = ins;
        dif.in_pc     = pc;
        dif.out_ready = ordy;
        flush         = fl;
        reset         = rst;
`ifdef DECODE_SKID_EN
        rdy = !fl && (q_instr.size() < 2);
`else
        rdy = !fl && (q_instr.size() == 0 || ordy);
`endif
        #1;
        if (!rst) check("in_ready", 32'(dif.in_ready), 32'(rdy));
        accepted = !rst && v && rdy;
        if (rst) begin
            q_instr.delete();
            q_pc.delete();
            m_count = '0;
            m_zero  = 1'b1;
        end else if (fl) begin
            q_instr.delete();
            q_pc.delete();
        end else begin
            if (q_instr.size() > 0 && ordy) begin
                void'(q_instr.pop_front());
                void'(q_pc.pop_front());
                m_count++;
            end
            if (accepted) begin
                q_instr.push_back(ins);
                q_pc.push_back(pc);
                m_zero = 1'b0;
            end
        end
        @(negedge clock);
        compare_outputs();
    endtask

    initial begin
        dif.in_valid  = 1'b0;
        dif.in_instr  = '0;
        dif.in_pc     = '0;
        dif.out_ready = 1'b0;
        @(negedge clock);
        run_cycle(0, 0, 0, 0, 0, 1, acc);
        run_cycle(0, 0, 0, 0, 0, 1, acc);
        check("rst_count", instr_count, 32'd0);

        // ADDI x5,x1,-1
        run_cycle(1, I_ADDI, 32'h100, 1, 0, 0, acc);
        check("t1_valid", 32'(dif.out_valid), 32'd1);
        check("t1_op", 32'(dif.out_operation), 32'b00000010011);
        check("t1_rs1", 32'(dif.out_rs1), 32'd1);
        check("t1_rd", 32'(dif.out_rd), 32'd5);
        check("t1_imm", dif.out_imm, 32'hFFFFFFFF);
        check("t1_wr", 32'(dif.out_writes_rd), 32'd1);
        // SUB x3,x1,x2 while ADDI transfers
        run_cycle(1, I_SUB, 32'h104, 1, 0, 0, acc);
        check("t1_count", instr_count, 32'd1);
        check("t2_op", 32'(dif.out_operation), 32'b10000110011);
        check("t2_rs1", 32'(dif.out_rs1), 32'd1);
        check("t2_rs2", 32'(dif.out_rs2), 32'd2);
        check("t2_rd", 32'(dif.out_rd), 32'd3);
        check("t2_imm", dif.out_imm, 32'd0);
        // BEQ x0,x0,-8
        run_cycle(1, I_BEQ, 32'h108, 1, 0, 0, acc);
        check("t3_op", 32'(dif.out_operation), 32'b00001100011);
        check("t3_imm", dif.out_imm, 32'hFFFFFFF8);
        check("t3_rd", 32'(dif.out_rd), 32'd0);
        check("t3_wr", 32'(dif.out_writes_rd), 32'd0);
        run_cycle(0, 0, 0, 1, 0, 0, acc);

        // Backpressure: two instructions, output stalled for three cycles
        base   = m_count;
        t4_ins = '{I_ADDI, I_SUB, 32'h0};
        idx    = 0;
        for (int c = 0; c < 4; c++) begin
            run_cycle(idx < 2, t4_ins[idx], 32'h200 + 32'(idx * 4), 0, 0, 0, acc);
            if (acc) idx++;
        end
        check("t4_stall_op", 32'(dif.out_operation), 32'b00000010011);
        check("t4_stall_ready", 32'(dif.in_ready), 32'd0);
        run_cycle(idx < 2, t4_ins[idx], 32'h200 + 32'(idx * 4), 1, 0, 0, acc);
        if (acc) idx++;
        check("t4_second_op", 32'(dif.out_operation), 32'b10000110011);
        for (int c = 0; c < 8 && (idx < 2 || q_instr.size() > 0); c++) begin
            run_cycle(idx < 2, t4_ins[idx], 32'h200 + 32'(idx * 4), 1, 0, 0, acc);
            if (acc) idx++;
        end
        check("t4_count", instr_count, base + 32'd2);

        // Illegal encodings
        run_cycle(1, I_AUI, 32'h300, 1, 0, 0, acc);
        check("t5_aui_ill", 32'(dif.out_illegal), 32'd1);
        check("t5_aui_op", 32'(dif.out_operation), 32'd0);
        check("t5_aui_wr", 32'(dif.out_writes_rd), 32'd0);
        check("t5_aui_pc", dif.out_pc, 32'h300);
        run_cycle(1, I_LW3, 32'h304, 1, 0, 0, acc);
        check("t5_lw_ill", 32'(dif.out_illegal), 32'd1);
        check("t5_lw_imm", dif.out_imm, 32'd0);

        // Flush with a held bundle and a pending input
        base = m_count;
        run_cycle(1, I_SUB, 32'h400, 1, 1, 0, acc);
        check("t6_flush_valid", 32'(dif.out_valid), 32'd0);
        check("t6_flush_count", instr_count, base);
        run_cycle(0, 0, 0, 1, 0, 0, acc);
        check("t6_not_consumed", 32'(dif.out_valid), 32'd0);

        // Reset during a stall
        run_cycle(1, I_ADDI, 32'h500, 0, 0, 0, acc);
        run_cycle(1, I_SUB, 32'h504, 0, 0, 0, acc);
        run_cycle(1, I_BEQ, 32'h508, 0, 0, 1, acc);
        check("t6_rst_valid", 32'(dif.out_valid), 32'd0);
        check("t6_rst_imm", dif.out_imm, 32'd0);
        check("t6_rst_op", 32'(dif.out_operation), 32'd0);
        check("t6_rst_count", instr_count, 32'd0);
        run_cycle(0, 0, 0, 0, 0, 0, acc);

        // Randomized traffic against the reference queue
        have = 1'b0;
        cur  = '0;
        for (int i = 0; i < 400; i++) begin
            if (!have) begin
                cur  = rand_instr();
                have = 1'b1;
            end
            run_cycle($urandom_range(0, 9) < 7, cur, $urandom, $urandom_range(0, 9) < 7,
                      $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0, acc);
            if (acc) have = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
